hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard controller for the four-stage MIPS core (IF, ID, EX, MW). It watches the instruction in ID and keeps its own record of the instructions in EX and MW. From that it drives the stall, bubble and flush controls and the ID-stage operand forwarding selects. It also sequences branch and jump recovery and counts stall and flush cycles for performance reporting.

## Interface
- CNT_W, 16, width of the performance counters
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- id_ir  in  32  instruction currently in ID
- id_valid  in  1  id_ir holds a real instruction
- ex_br_taken  in  1  EX-stage beq compare result; meaningful only in BR_WAIT
- pc_stall  out  1  hold PC
- ifid_hold  out  1  hold IF/ID register
- idex_bubble  out  1  load a nop into ID/EX
- ifid_flush  out  1  load a nop into IF/ID
- fwd_a  out  2  source for A: 0 register file, 1 EX ALU result, 2 MW_ALUout
- fwd_b  out  2  source for B (R-type/sw/beq rt operand), same encoding
- stall_cnt  out  CNT_W  cycles with pc_stall=1, saturating
- flush_cnt  out  CNT_W  cycles with ifid_flush=1, saturating

## Operation
- Decode of id_ir (opcode = [31:26], rs = [25:21], rt = [20:16], rd = [15:11], funct = [5:0]):
  - R-type (opcode 0) with funct 32/34/42: reads rs and rt; writes rd.
  - lw (35): reads rs; writes rt; is_lw flag set.
  - sw (43): reads rs and rt; no write.
  - beq (4): reads rs and rt; no write; is_beq flag set.
  - j (2): no reads, no write.
  - Any other encoding, id_valid=0, or a SKIP/BR_KILL cycle: nop (no reads, no write).
- Writes to register 0 are recorded as no-write. A register-0 source never matches a producer.
- Tracking slots: EX slot {rd, wr, is_lw, is_beq} and MW slot {rd, wr}. On every edge, MW is loaded from EX. EX is loaded from the decoded ID instruction, or with a nop if idex_bubble=1.
- Forwarding, per source and combinational: if the EX slot has wr, matching rd and not is_lw, select 1. Else if the MW slot has wr and matching rd, select 2. Else select 0. EX has priority over MW.
- Load-use hazard: the EX slot is an lw with wr, and its rd equals a source read by the ID instruction. In that case pc_stall=1, ifid_hold=1 and idex_bubble=1 for exactly one cycle. The same ID instruction is then re-evaluated and forwards from MW (select 2).
- FSM states are RUN, BR_WAIT, BR_KILL and SKIP.
  - RUN: hazard and forward logic as above. A beq issuing (no stall) moves to BR_WAIT. A j in ID asserts ifid_flush=1, issues to EX as a nop, and moves to SKIP.
  - BR_WAIT, ex_br_taken=1: ifid_flush=1 and idex_bubble=1; the ID instruction is discarded; move to BR_KILL.
  - BR_WAIT, ex_br_taken=0: behave exactly as RUN, including stall, a new beq re-entering BR_WAIT, and j handling. Otherwise move to RUN.
  - BR_KILL: ifid_flush=1, idex_bubble=1, pc_stall=0; go to RUN.
  - SKIP: idex_bubble=1, ifid_flush=0, pc_stall=0; go to RUN.
- Simultaneous events:
  - A taken branch overrides any load-use stall or j in ID in the same cycle; pc_stall is 0 in that cycle.
  - A load-use stall on a beq or j delays its issue. The state remains RUN or BR_WAIT-not-taken resolution applies, and the transition happens on the cycle it actually issues.
- Counters increment on each edge where the respective output is 1. They hold at all-ones.

## Timing
- All control and forward outputs are combinational from id_ir, id_valid, ex_br_taken and registered state. Tracking, FSM and counters update on the rising clk edge.
- Reset clears tracking slots to nop, sets state to RUN, and zeroes counters. With tracking cleared, every output reads 0 regardless of id_ir. Reset mid-branch abandons recovery immediately.
- Penalties:
  - Load-use: 1 cycle.
  - Taken beq: 2 flush cycles, one resolving cycle plus BR_KILL.
  - Not-taken beq: 0 cycles.
  - j: 1 flush cycle plus 1 SKIP cycle.

## Test plan
- Reset: assert rst while in BR_WAIT with counters at 5 → all outputs 0, counters 0, next beq sees RUN.
- Forwarding: 0x00221820 (add $3,$1,$2) then 0x00632020 (add $4,$3,$3) → fwd_a=fwd_b=1. With a nop inserted between them instead → fwd_a=fwd_b=2.
- Load-use: 0x8C010000 (lw $1,0($0)) then 0x00212020 (add $4,$1,$1) → one cycle of pc_stall=ifid_hold=idex_bubble=1, next cycle fwd_a=fwd_b=2, stall_cnt=1.
- Branch taken: 0x10000004 issues, next cycle ex_br_taken=1 → ifid_flush=idex_bubble=1 for 2 cycles, flush_cnt=2. Not taken → no flush, flush_cnt=0.
- Jump: 0x08000010 in ID → ifid_flush=1 for 1 cycle, then one SKIP cycle where a valid add in ID is not recorded, so a following consumer gets fwd=0.
- Saturation: preload via 2^CNT_W load-use stalls → stall_cnt holds 0xFFFF.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard controller for the four-stage MIPS pipeline: load-use stalls, ID-stage
// operand forwarding selects, beq/j recovery sequencing and stall/flush counters.
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      id_ir,
    input  logic             id_valid,
    input  logic             ex_br_taken,
    output logic             pc_stall,
    output logic             ifid_hold,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {RUN, BR_WAIT, BR_KILL, SKIP} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [4:0]       r_ex_rd;
    logic             r_ex_wr;
    logic             r_ex_lw;
    logic             r_ex_beq;
    logic [4:0]       r_mw_rd;
    logic             r_mw_wr;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic [4:0] w_rdf;
    logic       w_unused_ir;
    logic       w_taken;
    logic       w_run_like;
    logic       w_dec_en;
    logic       w_use_a;
    logic       w_use_b;
    logic       w_wr_raw;
    logic       w_wr;
    logic [4:0] w_dst;
    logic       w_lw;
    logic       w_beq;
    logic       w_j;
    logic       w_lu;
    logic       w_stall;
    logic       w_bubble;
    logic       w_flush;
    logic [1:0] w_fa;
    logic [1:0] w_fb;

    assign w_op        = id_ir[31:26];
    assign w_rs        = id_ir[25:21];
    assign w_rt        = id_ir[20:16];
    assign w_rdf       = id_ir[15:11];
    assign w_funct     = id_ir[5:0];
    assign w_unused_ir = ^id_ir[10:6];

    // The beq in EX resolves this cycle; a taken one discards whatever sits in ID.
    assign w_taken    = (r_state == BR_WAIT) && r_ex_beq && ex_br_taken;
    assign w_run_like = ((r_state == RUN) || (r_state == BR_WAIT)) && !w_taken;
    assign w_dec_en   = id_valid && w_run_like;

    // EX result is usable unless it is a load; MW is always usable. Register 0 never matches.
    function automatic logic [1:0] fwd_sel(
        input logic       use_src,
        input logic [4:0] src,
        input logic       ex_wr,
        input logic [4:0] ex_rd,
        input logic       ex_lw,
        input logic       mw_wr,
        input logic [4:0] mw_rd
    );
        logic [1:0] sel;
        sel = 2'd0;
        if (use_src && (src != 5'd0)) begin
            if (ex_wr && (ex_rd == src) && !ex_lw) begin
                sel = 2'd1;
            end else if (mw_wr && (mw_rd == src)) begin
                sel = 2'd2;
            end else begin
                sel = 2'd0;
            end
        end else begin
            sel = 2'd0;
        end
        return sel;
    endfunction

    // Instruction decode of the ID stage.
    always_comb begin
        w_use_a  = 1'b0;
        w_use_b  = 1'b0;
        w_wr_raw = 1'b0;
        w_dst    = 5'd0;
        w_lw     = 1'b0;
        w_beq    = 1'b0;
        w_j      = 1'b0;
        if (w_dec_en) begin
            case (w_op)
                6'd0: begin
                    if ((w_funct == 6'd32) || (w_funct == 6'd34) || (w_funct == 6'd42)) begin
                        w_use_a  = 1'b1;
                        w_use_b  = 1'b1;
                        w_wr_raw = 1'b1;
                        w_dst    = w_rdf;
                    end else begin
                        w_wr_raw = 1'b0;
                    end
                end
                6'd35: begin
                    w_use_a  = 1'b1;
                    w_wr_raw = 1'b1;
                    w_dst    = w_rt;
                    w_lw     = 1'b1;
                end
                6'd43: begin
                    w_use_a = 1'b1;
                    w_use_b = 1'b1;
                end
                6'd4: begin
                    w_use_a = 1'b1;
                    w_use_b = 1'b1;
                    w_beq   = 1'b1;
                end
                6'd2: begin
                    w_j = 1'b1;
                end
                default: begin
                    w_j = 1'b0;
                end
            endcase
        end else begin
            w_j = 1'b0;
        end
    end

    assign w_wr = w_wr_raw && (w_dst != 5'd0);
    assign w_lu = r_ex_wr && r_ex_lw &&
                  ((w_use_a && (w_rs == r_ex_rd)) || (w_use_b && (w_rt == r_ex_rd)));
    assign w_fa = fwd_sel(w_use_a, w_rs, r_ex_wr, r_ex_rd, r_ex_lw, r_mw_wr, r_mw_rd);
    assign w_fb = fwd_sel(w_use_b, w_rt, r_ex_wr, r_ex_rd, r_ex_lw, r_mw_wr, r_mw_rd);

    // Control outputs and next state; a stalled beq/j only changes state when it issues.
    always_comb begin
        w_stall  = 1'b0;
        w_bubble = 1'b0;
        w_flush  = 1'b0;
        w_next   = r_state;
        case (r_state)
            RUN, BR_WAIT: begin
                if (w_taken) begin
                    w_flush  = 1'b1;
                    w_bubble = 1'b1;
                    w_next   = BR_KILL;
                end else if (w_lu) begin
                    w_stall  = 1'b1;
                    w_bubble = 1'b1;
                    w_next   = RUN;
                end else if (w_j) begin
                    w_flush = 1'b1;
                    w_next  = SKIP;
                end else if (w_beq) begin
                    w_next = BR_WAIT;
                end else begin
                    w_next = RUN;
                end
            end
            BR_KILL: begin
                w_flush  = 1'b1;
                w_bubble = 1'b1;
                w_next   = RUN;
            end
            SKIP: begin
                w_bubble = 1'b1;
                w_next   = RUN;
            end
            default: begin
                w_next = RUN;
            end
        endcase
    end

    assign pc_stall    = w_stall && !rst;
    assign ifid_hold   = w_stall && !rst;
    assign idex_bubble = w_bubble && !rst;
    assign ifid_flush  = w_flush && !rst;
    assign fwd_a       = rst ? 2'd0 : w_fa;
    assign fwd_b       = rst ? 2'd0 : w_fb;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;

    // Tracking slots, FSM state and saturating performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RUN;
            r_ex_rd     <= 5'd0;
            r_ex_wr     <= 1'b0;
            r_ex_lw     <= 1'b0;
            r_ex_beq    <= 1'b0;
            r_mw_rd     <= 5'd0;
            r_mw_wr     <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_next;
            r_mw_rd <= r_ex_rd;
            r_mw_wr <= r_ex_wr;
            if (w_bubble) begin
                r_ex_rd  <= 5'd0;
                r_ex_wr  <= 1'b0;
                r_ex_lw  <= 1'b0;
                r_ex_beq <= 1'b0;
            end else begin
                r_ex_rd  <= w_dst;
                r_ex_wr  <= w_wr;
                r_ex_lw  <= w_lw && w_wr;
                r_ex_beq <= w_beq;
            end
            if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
            if (w_flush && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end else begin
                r_flush_cnt <= r_flush_cnt;
            end
        end
    end

endmodule
